// File: rtl/ppu_dma_pkg.sv
// Shared definitions for the sprite DMA engine: FSM encoding, default geometry
// and the CPU-visible register address used by the bus decoder.
package ppu_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam int          DMA_LENGTH_DEFAULT   = 256;
  localparam logic [15:0] OAMDATA_ADDR_DEFAULT = 16'h2004;
  localparam logic [15:0] DMA_REG_ADDR         = 16'h4014;

  // Source address of one byte of the transfer.
  function automatic logic [15:0] pageAddress(input logic [7:0] page,
                                              input logic [7:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/oam_dma_controller_if.sv
// Bus-side signal bundle of the sprite DMA engine. The master side is the
// CPU/bus fabric, the slave side is the engine itself.
interface oam_dma_controller_if;
  import ppu_dma_pkg::*;

  logic        clock_EN;
  logic        dmaWrite;
  logic [7:0]  dmaPage;
  logic        busStall;
  logic [7:0]  busData_IN;
  logic        cpuHalt;
  logic        busRead;
  logic [15:0] busAddress;
  logic        oamWrite;
  logic [7:0]  oamData;
  logic        busy;
  dma_state_t  dbgState;

  // Handshake: dmaWrite and busStall are sampled only on clock_EN edges; a
  // busStall seen on an edge freezes the CPU cycle that edge begins. oamWrite
  // is a one-CPU-cycle strobe with no back-pressure from the sprite handler.
  modport master (
    output clock_EN, dmaWrite, dmaPage, busStall, busData_IN,
    input  cpuHalt, busRead, busAddress, oamWrite, oamData, busy, dbgState
  );

  modport slave (
    input  clock_EN, dmaWrite, dmaPage, busStall, busData_IN,
    output cpuHalt, busRead, busAddress, oamWrite, oamData, busy, dbgState
  );

endinterface

// File: rtl/oam_dma_controller.sv
// $4014 sprite DMA: halts the CPU, copies one page into OAM through the
// $2004 write port, then releases the CPU. All outputs are registered.
module oam_dma_controller
  import ppu_dma_pkg::*;
#(
  parameter int          DMA_LENGTH   = DMA_LENGTH_DEFAULT,
  parameter logic [15:0] OAMDATA_ADDR = OAMDATA_ADDR_DEFAULT
) (
  input logic                 clock,
  input logic                 reset,
  oam_dma_controller_if.slave bus
);

  localparam logic [7:0] LAST_INDEX = 8'(DMA_LENGTH - 1);

  dma_state_t  state;
  logic        cpuParity;
  logic        stalled;
  logic [7:0]  pageReg;
  logic [7:0]  index;
  logic [7:0]  dataReg;

  logic        cpuHaltReg;
  logic        busReadReg;
  logic        oamWriteReg;
  logic [7:0]  oamDataReg;
  logic [15:0] busAddressReg;

  dma_state_t  nextState;
  logic [7:0]  nextPage;
  logic [7:0]  nextIndex;
  logic [7:0]  nextData;
  logic        nextStall;
  logic [15:0] nextAddress;

  // A stalled cycle performs no work, so the cycle after it repeats the same
  // state with the same index and data.
  always_comb begin
    nextState = state;
    nextPage  = pageReg;
    nextIndex = index;
    nextData  = dataReg;
    if (!stalled) begin
      case (state)
        IDLE: begin
          if (bus.dmaWrite) begin
            nextPage  = bus.dmaPage;
            nextIndex = 8'd0;
            nextState = HALT;
          end
        end
        HALT:  nextState = cpuParity ? READ : ALIGN;
        ALIGN: nextState = READ;
        READ: begin
          nextData  = bus.busData_IN;
          nextState = WRITE;
        end
        WRITE: begin
          nextIndex = index + 8'd1;
          nextState = (index == LAST_INDEX) ? IDLE : READ;
        end
        default: nextState = IDLE;
      endcase
    end
    nextStall = bus.busStall && (nextState != IDLE);

    nextAddress = 16'h0000;
    if (nextState == READ) begin
      nextAddress = pageAddress(nextPage, nextIndex);
    end else if (nextState == WRITE) begin
      nextAddress = OAMDATA_ADDR;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cpuParity     <= 1'b0;
      stalled       <= 1'b0;
      pageReg       <= 8'd0;
      index         <= 8'd0;
      dataReg       <= 8'd0;
      cpuHaltReg    <= 1'b0;
      busReadReg    <= 1'b0;
      oamWriteReg   <= 1'b0;
      oamDataReg    <= 8'd0;
      busAddressReg <= 16'h0000;
    end else if (bus.clock_EN) begin
      cpuParity     <= ~cpuParity;
      state         <= nextState;
      stalled       <= nextStall;
      pageReg       <= nextPage;
      index         <= nextIndex;
      dataReg       <= nextData;
      cpuHaltReg    <= (nextState != IDLE);
      busReadReg    <= (nextState == READ);
      // A stalled WRITE cycle keeps the strobe low; the byte goes out on the repeat.
      oamWriteReg   <= (nextState == WRITE) && !nextStall;
      oamDataReg    <= (nextState == WRITE) ? nextData : 8'd0;
      busAddressReg <= nextAddress;
    end
  end

  assign bus.cpuHalt    = cpuHaltReg;
  assign bus.busy       = cpuHaltReg;
  assign bus.busRead    = busReadReg;
  assign bus.busAddress = busAddressReg;
  assign bus.oamWrite   = oamWriteReg;
  assign bus.oamData    = oamDataReg;
  assign bus.dbgState   = state;

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Sprite DMA engine for the $4014 register: on a CPU write of page number P it halts the CPU, copies the 256 bytes at CPU addresses P00–PFF into primary OAM, then releases the CPU. It sits between the CPU bus and the sprite handler. Each byte is presented on the sprite handler's OAM data-write port (cpuComm_EN / cpuRW=0 / cpuData_IN), so primary OAM is filled exactly as CPU writes to $2004 would fill it.

## Interface
Parameters:
- DMA_LENGTH, 256, bytes per transfer (power of two, ≤256)
- OAMDATA_ADDR, 16'h2004, bus address driven during write cycles

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clock_EN  in  1  one-cycle enable marking each CPU cycle; all state advances only when high
- dmaWrite  in  1  CPU write strobe to $4014, sampled with clock_EN
- dmaPage  in  8  data written to $4014 (source page)
- busStall  in  1  external bus steal (DMC/RDY); freezes the engine for that CPU cycle
- busData_IN  in  8  CPU bus read data
- cpuHalt  out  1  high while the engine owns the bus
- busRead  out  1  engine is performing a bus read this cycle
- busAddress  out  16  bus address during engine-owned cycles, 0 otherwise
- oamWrite  out  1  OAM write strobe to the sprite handler (drives cpuComm_EN)
- oamData  out  8  byte to OAM (drives cpuData_IN)
- busy  out  1  transfer in progress, including the halt cycle

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- cpuParity flop: toggles on every clock_EN; reset value 0.
- IDLE: on clock_EN && dmaWrite:
  - latch dmaPage into pageReg
  - clear index (8 bits)
  - go to HALT
- HALT: cpuHalt=1, no bus activity.
  - If cpuParity==1 this cycle, go to READ.
  - Otherwise go to ALIGN.
  - Reads therefore always land on parity-0 cycles.
- ALIGN: one idle cycle with cpuHalt=1, then READ.
- READ: busRead=1, busAddress={pageReg,index}. At the end of the cycle, latch busData_IN into dataReg and go to WRITE.
- WRITE: oamWrite=1, oamData=dataReg, busAddress=OAMDATA_ADDR. At the end of the cycle, index increments.
  - index == DMA_LENGTH-1: go to IDLE.
  - Otherwise: go to READ.
- busStall high on a clock_EN cycle: state, index and dataReg hold, and cpuParity still toggles.
  - A stalled READ is repeated: busRead stays asserted and the data is re-latched on the next unstalled cycle.
  - A stalled WRITE holds oamWrite=0 for that cycle and does not write.
- dmaWrite while busy: ignored. pageReg is not updated and the transfer is not restarted.
- Index wraps 0xFF→0x00 only as the terminal condition; the engine never performs a 257th access.
- The start address within OAM is the sprite handler's current OAMADDR. The engine does not touch it; the handler's OAMADDR auto-increment wraps modulo 256.

## Timing
- Reset (asynchronous): state=IDLE, cpuParity=0, pageReg=0, index=0, dataReg=0.
  - All outputs 0 immediately, including cpuHalt.
  - Reset mid-transfer aborts it. No partial-byte write follows.
- All outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.
- cpuHalt and busy rise in the CPU cycle after the accepted dmaWrite.
- Unstalled duration from HALT to the first IDLE cycle:
  - HALT on parity 1: 513 cycles.
  - HALT on parity 0: 514 cycles.
- cpuHalt falls in the cycle after the last WRITE.
- oamWrite is a single-CPU-cycle pulse per byte, 256 pulses per transfer.
- Between clock_EN pulses, all outputs hold their values.

## Structure
- Shared package ppu_dma_pkg holds:
  - the state enum (dma_state_t: IDLE, HALT, ALIGN, READ, WRITE)
  - OAMDATA_ADDR and DMA_LENGTH defaults
  - the DMA register address 16'h4014, for the bus decoder
- Single module, no sub-module. Parity, state, index and data registers live inline.

## Test plan
- Reset, then dmaWrite with dmaPage=8'h02 issued on a parity-1 cycle, so HALT lands on parity 0:
  - ALIGN is present.
  - busAddress steps 16'h0200..16'h02FF.
  - 256 oamWrite pulses carry memory[0x0200+i].
  - cpuHalt lasts 514 cycles.
- Same transfer started one cycle later (HALT on parity 1) → no ALIGN, cpuHalt high for exactly 513 cycles.
- busStall asserted for 3 cycles during the READ of index 8'h10:
  - busRead held for 4 cycles.
  - The correct byte 0x0210 is written once.
  - Total duration extends by 3.
- busStall during WRITE of index 8'h20 → no oamWrite in the stalled cycle, a single write afterward, no duplicate.
- Second dmaWrite with dmaPage=8'h07 at index 8'h40 → ignored; all 256 bytes still come from page 8'h02.
- reset asserted at index 8'h80 during WRITE:
  - cpuHalt, oamWrite and busy drop asynchronously.
  - A fresh dmaWrite afterward starts again from index 0.
